// File: rtl/div_issue_ctrl.sv
// EX-stage issue controller for the iterative divider.
// Decodes RV32M DIV/DIVU/REM/REMU, resolves divide-by-zero and signed
// overflow locally, and serves repeated operand pairs from a one-entry cache.
// All other divides go to the divider, and the pipeline is stalled until the
// result comes back.
module div_issue_ctrl #(
    parameter int XLEN       = 32,
    parameter bit PAIR_CACHE = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ex_valid,
    input  logic [2:0]      ex_funct3,
    input  logic [XLEN-1:0] ex_rs1_val,
    input  logic [XLEN-1:0] ex_rs2_val,
    input  logic [4:0]      ex_rd,
    input  logic            flush,
    output logic            stall_req,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            div_start,
    output logic            div_is_signed,
    output logic            div_is_rem,
    output logic [XLEN-1:0] div_dividend,
    output logic [XLEN-1:0] div_divisor,
    input  logic [XLEN-1:0] div_result,
    input  logic [XLEN-1:0] div_remainder,
    input  logic            div_done,
    input  logic            div_busy
);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN, S_RESP} state_t;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state_q, state_d;
    logic [XLEN-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
    logic            signed_q, signed_d, rem_q, rem_d;
    logic [4:0]      rd_q, rd_d, wb_rd_q, wb_rd_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic            c_valid_q, c_valid_d, c_signed_q, c_signed_d;
    logic [XLEN-1:0] c_rs1_q, c_rs1_d, c_rs2_q, c_rs2_d;
    logic [XLEN-1:0] c_quo_q, c_quo_d, c_rem_q, c_rem_d;
    // Set when a flush lands on the same cycle as div_done: the divider has
    // already finished, so DRAIN must not wait for another done pulse.
    logic            drain_skip_q, drain_skip_d;

    logic div_op, ex_signed, ex_rem, cache_hit;

    assign div_op    = ex_valid & ex_funct3[2];
    assign ex_signed = ~ex_funct3[0];
    assign ex_rem    = ex_funct3[1];
    assign cache_hit = PAIR_CACHE && c_valid_q && (c_rs1_q == ex_rs1_val) &&
                       (c_rs2_q == ex_rs2_val) && (c_signed_q == ex_signed);

    assign div_dividend  = rs1_q;
    assign div_divisor   = rs2_q;
    assign div_is_signed = signed_q;
    assign div_is_rem    = rem_q;
    assign wb_data       = wb_data_q;
    assign wb_rd         = wb_rd_q;

    // Stall request, gated by reset so every output reads 0 while reset is held.
    always_comb begin
        stall_req = ~reset & ((div_op & (state_q != S_RESP)) |
                              (state_q == S_ISSUE) | (state_q == S_WAIT));
    end

    // Next-state, operand latching, cache update and pulse outputs.
    always_comb begin
        state_d      = state_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        signed_d     = signed_q;
        rem_d        = rem_q;
        rd_d         = rd_q;
        wb_rd_d      = wb_rd_q;
        wb_data_d    = wb_data_q;
        c_valid_d    = c_valid_q;
        c_signed_d   = c_signed_q;
        c_rs1_d      = c_rs1_q;
        c_rs2_d      = c_rs2_q;
        c_quo_d      = c_quo_q;
        c_rem_d      = c_rem_q;
        drain_skip_d = drain_skip_q;
        div_start    = 1'b0;
        wb_valid     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (div_op && !flush && !div_busy) begin
                    rs1_d    = ex_rs1_val;
                    rs2_d    = ex_rs2_val;
                    signed_d = ex_signed;
                    rem_d    = ex_rem;
                    rd_d     = ex_rd;
                    if (ex_rs2_val == '0) begin
                        wb_data_d = ex_rem ? ex_rs1_val : '1;
                        wb_rd_d   = ex_rd;
                        state_d   = S_RESP;
                    end else if (ex_signed && (ex_rs1_val == INT_MIN) && (ex_rs2_val == '1)) begin
                        wb_data_d = ex_rem ? '0 : INT_MIN;
                        wb_rd_d   = ex_rd;
                        state_d   = S_RESP;
                    end else if (cache_hit) begin
                        wb_data_d = ex_rem ? c_rem_q : c_quo_q;
                        wb_rd_d   = ex_rd;
                        state_d   = S_RESP;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (!div_busy && !div_done) begin
                    div_start = 1'b1;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    drain_skip_d = div_done;
                    state_d      = S_DRAIN;
                end else if (div_done) begin
                    wb_data_d  = rem_q ? div_remainder : div_result;
                    wb_rd_d    = rd_q;
                    c_valid_d  = 1'b1;
                    c_signed_d = signed_q;
                    c_rs1_d    = rs1_q;
                    c_rs2_d    = rs2_q;
                    c_quo_d    = div_result;
                    c_rem_d    = div_remainder;
                    state_d    = S_RESP;
                end
            end
            S_DRAIN: begin
                if (div_done || drain_skip_q) begin
                    drain_skip_d = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            S_RESP: begin
                wb_valid = ~flush;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, operand, result and cache registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            rs1_q        <= '0;
            rs2_q        <= '0;
            signed_q     <= 1'b0;
            rem_q        <= 1'b0;
            rd_q         <= '0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
            c_valid_q    <= 1'b0;
            c_signed_q   <= 1'b0;
            c_rs1_q      <= '0;
            c_rs2_q      <= '0;
            c_quo_q      <= '0;
            c_rem_q      <= '0;
            drain_skip_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            signed_q     <= signed_d;
            rem_q        <= rem_d;
            rd_q         <= rd_d;
            wb_rd_q      <= wb_rd_d;
            wb_data_q    <= wb_data_d;
            c_valid_q    <= c_valid_d;
            c_signed_q   <= c_signed_d;
            c_rs1_q      <= c_rs1_d;
            c_rs2_q      <= c_rs2_d;
            c_quo_q      <= c_quo_d;
            c_rem_q      <= c_rem_d;
            drain_skip_q <= drain_skip_d;
        end
    end

endmodule
